// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed 7-segment scanner for the BCD time-of-day bus.
// Captures a coherent snapshot once per frame and scans it out slot by slot.
module clock_display_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int GAP      = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] h2,
  input  logic [1:0] h1,
  input  logic [3:0] m2,
  input  logic [2:0] m1,
  input  logic [3:0] s2,
  input  logic [2:0] s1,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] CNT_GAP  = 16'(GAP);
  localparam logic [6:0]  SEG_DASH = 7'h40;

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        tick;
  logic        frame_end;

  logic [3:0] snap_h2;
  logic [1:0] snap_h1;
  logic [3:0] snap_m2;
  logic [2:0] snap_m1;
  logic [3:0] snap_s2;
  logic [2:0] snap_s1;

  logic [3:0] digit;
  logic       dash;
  logic       blank;
  logic       hour_over;
  logic [6:0] seg_next;
  logic [5:0] an_next;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == 3'd5);
  assign hour_over = (snap_h1 == 2'd2) && (snap_h2 > 4'd3);

  // Slot select and validity; a dash always wins over leading-zero blanking.
  always_comb begin
    digit = 4'd0;
    dash  = 1'b0;
    blank = 1'b0;
    case (idx)
      3'd0: begin
        digit = snap_s2;
        dash  = (snap_s2 > 4'd9);
      end
      3'd1: begin
        digit = {1'b0, snap_s1};
        dash  = (snap_s1 > 3'd5);
      end
      3'd2: begin
        digit = snap_m2;
        dash  = (snap_m2 > 4'd9);
      end
      3'd3: begin
        digit = {1'b0, snap_m1};
        dash  = (snap_m1 > 3'd5);
      end
      3'd4: begin
        digit = snap_h2;
        dash  = (snap_h2 > 4'd9) || hour_over;
      end
      3'd5: begin
        digit = {2'b00, snap_h1};
        dash  = (snap_h1 == 2'd3) || hour_over;
        blank = (BLANK_LZ != 0) && (snap_h1 == 2'd0);
      end
      default: begin
        digit = 4'd0;
        dash  = 1'b0;
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    seg_next = 7'h00;
    if (dash) begin
      seg_next = SEG_DASH;
    end else if (!blank) begin
      case (digit)
        4'd0:    seg_next = 7'h3F;
        4'd1:    seg_next = 7'h06;
        4'd2:    seg_next = 7'h5B;
        4'd3:    seg_next = 7'h4F;
        4'd4:    seg_next = 7'h66;
        4'd5:    seg_next = 7'h6D;
        4'd6:    seg_next = 7'h7D;
        4'd7:    seg_next = 7'h07;
        4'd8:    seg_next = 7'h7F;
        4'd9:    seg_next = 7'h6F;
        default: seg_next = SEG_DASH;
      endcase
    end
  end

  // Enables stay off for the first GAP cycles of a slot to avoid ghosting.
  always_comb begin
    an_next = 6'b000000;
    if (cnt >= CNT_GAP) begin
      an_next = 6'b000001 << idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 16'd0;
      idx         <= 3'd0;
      snap_h2     <= 4'd0;
      snap_h1     <= 2'd0;
      snap_m2     <= 4'd0;
      snap_m1     <= 3'd0;
      snap_s2     <= 4'd0;
      snap_s1     <= 3'd0;
      seg         <= 7'h00;
      an          <= 6'b000000;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? 16'd0 : cnt + 16'd1;
      if (tick) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      // Inputs are only sampled at the frame boundary so a frame never tears.
      if (frame_end) begin
        snap_h2 <= h2;
        snap_h1 <= h1;
        snap_m2 <= m2;
        snap_m1 <= m1;
        snap_s2 <= s2;
        snap_s1 <= s1;
      end
      seg         <= seg_next;
      an          <= an_next;
      frame_start <= frame_end;
    end
  end

endmodule
